// File: rtl/pipeline_memory.sv
// Memory-access stage: one blocking req/ack data-memory access per instruction,
// aligned/extended load return. Optional bus timeout via PIPELINE_MEMORY_TIMEOUT_EN.
module pipeline_memory #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_stall,
    input  logic        in_decode_exception,
    input  logic [2:0]  in_alu_exception,
    input  logic [4:0]  in_rd_index,
    input  logic        in_regwrite_enable,
    input  logic        in_memread_enable,
    input  logic        in_memwrite_enable,
    input  logic        in_memop_disable,
    input  logic [1:0]  in_mem_size,
    input  logic        in_mem_signed,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    input  logic        dmem_err,
    output logic        out_valid,
    output logic        out_decode_exception,
    output logic [2:0]  out_alu_exception,
    output logic [4:0]  out_rd_index,
    output logic        out_memread_enable,
    output logic        out_memop_disable,
    output logic [31:0] out_alu_out,
    output logic        out_regwrite_enable,
    output logic [31:0] mem_out,
    output logic [2:0]  mem_exception
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_dec_exc;
    logic [2:0]  r_alu_exc;
    logic [4:0]  r_rd;
    logic        r_rwe;
    logic        r_mre;
    logic        r_mod;
    logic [31:0] r_alu_out;

    logic        w_bypass;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_tmo;
    logic        w_done;

    assign in_stall = (r_state == REQ);

    always_comb begin
        w_bypass   = in_memop_disable | ~(in_memread_enable | in_memwrite_enable)
                   | in_decode_exception | (|in_alu_exception);
        w_misalign = 1'b0;
        w_be       = 4'hF;
        w_wdata    = in_store_data;
        case (in_mem_size)
            2'd0: begin
                w_be    = 4'b0001 << in_alu_out[1:0];
                w_wdata = {4{in_store_data[7:0]}};
            end
            2'd1: begin
                w_misalign = in_alu_out[0];
                w_be       = 4'b0011 << in_alu_out[1:0];
                w_wdata    = {2{in_store_data[15:0]}};
            end
            default: w_misalign = |in_alu_out[1:0];
        endcase
    end

    // Lane select uses the address latched at accept; rdata is only valid with ack.
    always_comb begin
        w_byte = dmem_rdata[8*r_addr_lo +: 8];
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_size)
            2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    assign w_tmo = (r_state == REQ) & ~dmem_ack & ~dmem_err & (r_tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (r_state == IDLE)
            r_tmo_cnt <= '0;
        else if (~dmem_ack & ~dmem_err)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_LIMIT;
    assign w_tmo        = 1'b0;
`endif

    assign w_done = dmem_ack | dmem_err | w_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state              <= IDLE;
            r_addr_lo            <= '0;
            r_size               <= '0;
            r_signed             <= 1'b0;
            r_dec_exc            <= 1'b0;
            r_alu_exc            <= '0;
            r_rd                 <= '0;
            r_rwe                <= 1'b0;
            r_mre                <= 1'b0;
            r_mod                <= 1'b0;
            r_alu_out            <= '0;
            dmem_req             <= 1'b0;
            dmem_we              <= 1'b0;
            dmem_addr            <= '0;
            dmem_be              <= '0;
            dmem_wdata           <= '0;
            out_valid            <= 1'b0;
            out_decode_exception <= 1'b0;
            out_alu_exception    <= '0;
            out_rd_index         <= '0;
            out_memread_enable   <= 1'b0;
            out_memop_disable    <= 1'b0;
            out_alu_out          <= '0;
            out_regwrite_enable  <= 1'b0;
            mem_out              <= '0;
            mem_exception        <= '0;
        end else begin
            out_valid           <= 1'b0;
            out_regwrite_enable <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    if (w_bypass || w_misalign) begin
                        out_valid            <= 1'b1;
                        out_decode_exception <= in_decode_exception;
                        out_alu_exception    <= in_alu_exception;
                        out_rd_index         <= in_rd_index;
                        out_memread_enable   <= in_memread_enable;
                        out_memop_disable    <= in_memop_disable;
                        out_alu_out          <= in_alu_out;
                        out_regwrite_enable  <= in_regwrite_enable;
                        mem_out              <= '0;
                        mem_exception        <= {2'b00, ~w_bypass & w_misalign};
                    end else begin
                        r_state    <= REQ;
                        r_addr_lo  <= in_alu_out[1:0];
                        r_size     <= in_mem_size;
                        r_signed   <= in_mem_signed;
                        r_dec_exc  <= in_decode_exception;
                        r_alu_exc  <= in_alu_exception;
                        r_rd       <= in_rd_index;
                        r_rwe      <= in_regwrite_enable;
                        r_mre      <= in_memread_enable;
                        r_mod      <= in_memop_disable;
                        r_alu_out  <= in_alu_out;
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_memwrite_enable;
                        dmem_addr  <= {in_alu_out[31:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata;
                    end
                end
                REQ: if (w_done) begin
                    r_state              <= IDLE;
                    dmem_req             <= 1'b0;
                    out_valid            <= 1'b1;
                    out_decode_exception <= r_dec_exc;
                    out_alu_exception    <= r_alu_exc;
                    out_rd_index         <= r_rd;
                    out_memread_enable   <= r_mre;
                    out_memop_disable    <= r_mod;
                    out_alu_out          <= r_alu_out;
                    out_regwrite_enable  <= r_rwe;
                    mem_out              <= (dmem_ack && !dmem_we) ? w_load : 32'd0;
                    mem_exception        <= {w_tmo, ~dmem_ack & dmem_err, 1'b0};
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_memory.sv
// Directed bench for pipeline_memory; timeout case runs only when
// PIPELINE_MEMORY_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES=4).
module tb_pipeline_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_stall;
    logic        in_decode_exception;
    logic [2:0]  in_alu_exception;
    logic [4:0]  in_rd_index;
    logic        in_regwrite_enable, in_memread_enable, in_memwrite_enable, in_memop_disable;
    logic [1:0]  in_mem_size;
    logic        in_mem_signed;
    logic [31:0] in_alu_out, in_store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack, dmem_err;
    logic        out_valid, out_decode_exception;
    logic [2:0]  out_alu_exception;
    logic [4:0]  out_rd_index;
    logic        out_memread_enable, out_memop_disable, out_regwrite_enable;
    logic [31:0] out_alu_out, mem_out;
    logic [2:0]  mem_exception;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_memory #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_stall(in_stall),
        .in_decode_exception(in_decode_exception), .in_alu_exception(in_alu_exception),
        .in_rd_index(in_rd_index), .in_regwrite_enable(in_regwrite_enable),
        .in_memread_enable(in_memread_enable), .in_memwrite_enable(in_memwrite_enable),
        .in_memop_disable(in_memop_disable), .in_mem_size(in_mem_size),
        .in_mem_signed(in_mem_signed), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .out_valid(out_valid), .out_decode_exception(out_decode_exception),
        .out_alu_exception(out_alu_exception), .out_rd_index(out_rd_index),
        .out_memread_enable(out_memread_enable), .out_memop_disable(out_memop_disable),
        .out_alu_out(out_alu_out), .out_regwrite_enable(out_regwrite_enable),
        .mem_out(mem_out), .mem_exception(mem_exception)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 0; in_decode_exception = 0; in_alu_exception = 0; in_rd_index = 0;
        in_regwrite_enable = 0; in_memread_enable = 0; in_memwrite_enable = 0;
        in_memop_disable = 0; in_mem_size = 0; in_mem_signed = 0;
        in_alu_out = 0; in_store_data = 0;
    endtask

    // Present a memory op for one edge (accepted since stage is idle).
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        clr_in();
        in_valid = 1; in_memread_enable = rd; in_memwrite_enable = wr;
        in_mem_size = sz; in_mem_signed = sgn; in_alu_out = addr; in_store_data = wd;
        in_regwrite_enable = rd; in_rd_index = 5'd7;
        step();
        in_valid = 0;
    endtask

    // Answer the pending request on the next edge and check the retired load value.
    task automatic ack_load(input string tag, input logic [31:0] rdata, input logic [31:0] exp);
        dmem_rdata = rdata; dmem_ack = 1;
        step();
        dmem_ack = 0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, mem_out, exp);
    endtask

    initial begin
        int stall_cnt;
        clr_in();
        rst = 1; dmem_rdata = 0; dmem_ack = 0; dmem_err = 0;
        step(); step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(in_stall), 0);
        chk("rst_memout", mem_out, 0);
        chk("rst_exc", 32'(mem_exception), 0);
        rst = 0;
        step();

        // ALU op bypass
        clr_in();
        in_valid = 1; in_memop_disable = 1; in_alu_out = 32'h1234;
        in_regwrite_enable = 1; in_rd_index = 5'd5;
        step();
        in_valid = 0;
        chk("alu_valid", 32'(out_valid), 1);
        chk("alu_out", out_alu_out, 32'h1234);
        chk("alu_rwe", 32'(out_regwrite_enable), 1);
        chk("alu_rd", 32'(out_rd_index), 5);
        chk("alu_req", 32'(dmem_req), 0);
        step();
        chk("alu_valid_pulse", 32'(out_valid), 0);
        chk("alu_rwe_forced0", 32'(out_regwrite_enable), 0);
        chk("alu_out_hold", out_alu_out, 32'h1234);

        // lb signed at 0x1003, 3 wait cycles
        issue(1, 0, 2'd0, 1, 32'h1003, 0);
        chk("lb_req", 32'(dmem_req), 1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_be", 32'(dmem_be), 32'h8);
        chk("lb_we", 32'(dmem_we), 0);
        stall_cnt = int'(in_stall);
        for (int i = 0; i < 3; i++) begin
            step();
            stall_cnt += int'(in_stall);
            chk("lb_wait_valid", 32'(out_valid), 0);
        end
        ack_load("lb", 32'h80FFFFFF, 32'hFFFFFF80);
        chk("lb_stall_cycles", 32'(stall_cnt), 4);
        chk("lb_exc", 32'(mem_exception), 0);
        chk("lb_stall_drop", 32'(in_stall), 0);
        chk("lb_req_drop", 32'(dmem_req), 0);

        // sh at 0x2002
        issue(0, 1, 2'd1, 0, 32'h2002, 32'hABCD1234);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h12341234);
        chk("sh_we", 32'(dmem_we), 1);
        chk("sh_addr", dmem_addr, 32'h2000);
        ack_load("sh", 32'hDEADBEEF, 32'h0);
        chk("sh_exc", 32'(mem_exception), 0);

        // Misaligned lw
        issue(1, 0, 2'd2, 0, 32'h3001, 0);
        chk("mis_valid", 32'(out_valid), 1);
        chk("mis_exc", 32'(mem_exception), 1);
        chk("mis_rwe", 32'(out_regwrite_enable), 1);
        chk("mis_req", 32'(dmem_req), 0);
        step();
        chk("mis_req2", 32'(dmem_req), 0);

        // Bus error, then ack+err together
        issue(1, 0, 2'd2, 0, 32'h3000, 0);
        dmem_err = 1; dmem_rdata = 32'hFFFFFFFF;
        step();
        dmem_err = 0;
        chk("err_valid", 32'(out_valid), 1);
        chk("err_exc", 32'(mem_exception), 2);
        chk("err_memout", mem_out, 0);
        issue(1, 0, 2'd2, 0, 32'h3004, 0);
        dmem_err = 1;
        ack_load("ackerr", 32'h11223344, 32'h11223344);
        dmem_err = 0;
        chk("ackerr_exc", 32'(mem_exception), 0);

        // Halfword / unsigned byte extension
        issue(1, 0, 2'd1, 0, 32'h3002, 0);
        ack_load("lhu", 32'h80010000, 32'h00008001);
        issue(1, 0, 2'd1, 1, 32'h3002, 0);
        ack_load("lh", 32'h80010000, 32'hFFFF8001);
        issue(1, 0, 2'd0, 0, 32'h1001, 0);
        ack_load("lbu", 32'h00008000, 32'h00000080);

        // Spurious ack in IDLE
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        chk("spur_valid", 32'(out_valid), 0);
        chk("spur_stall", 32'(in_stall), 0);

        // Reset in the second REQ cycle, late ack ignored
        issue(1, 0, 2'd2, 0, 32'h4000, 0);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rstreq_req", 32'(dmem_req), 0);
        chk("rstreq_valid", 32'(out_valid), 0);
        chk("rstreq_stall", 32'(in_stall), 0);
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        chk("late_ack_valid", 32'(out_valid), 0);
        chk("late_ack_stall", 32'(in_stall), 0);

`ifdef PIPELINE_MEMORY_TIMEOUT_EN
        begin
            int cyc = 0;
            issue(1, 0, 2'd2, 0, 32'h5000, 0);
            while (!out_valid && cyc < 20) begin
                step();
                cyc++;
            end
            chk("tmo_cycles", 32'(cyc), 4);
            chk("tmo_exc", 32'(mem_exception), 4);
            chk("tmo_memout", mem_out, 0);
            chk("tmo_req", 32'(dmem_req), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_memory.md
Name: pipeline_memory

Overview:
Memory-access stage between the ALU stage and the register-writeback stage. It accepts one instruction per handshake and performs at most one data-memory access, blocking, over a req/ack bus. It returns loaded data aligned and sign/zero-extended. Its registered outputs (mem_out, mem_exception and the pass-through fields) drive the writeback stage directly.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles in REQ before timeout abort (used only with PIPELINE_MEMORY_TIMEOUT_EN); range 1..255.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ALU stage presents an instruction
in_stall  output  1  high = stage busy, upstream must hold its inputs
in_decode_exception  input  1  passed through
in_alu_exception  input  3  passed through
in_rd_index  input  5  passed through
in_regwrite_enable  input  1  passed through
in_memread_enable  input  1  load
in_memwrite_enable  input  1  store
in_memop_disable  input  1  suppress any memory op; passed through
in_mem_size  input  2  0=byte, 1=half, 2=word; 3 is treated as word
in_mem_signed  input  1  sign-extend loads
in_alu_out  input  32  effective address / ALU result; passed through
in_store_data  input  32  rt value for stores
dmem_req  output  1  bus request
dmem_we  output  1  1=write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  output  4  byte enables, little-endian lanes (be[0]=bits 7:0)
dmem_wdata  output  32  store data replicated to lanes
dmem_rdata  input  32  read data, valid with ack
dmem_ack  input  1  transfer complete
dmem_err  input  1  bus error, terminates transfer
out_valid  output  1  one-cycle pulse per retired instruction
out_decode_exception, out_alu_exception, out_rd_index, out_memread_enable, out_memop_disable, out_alu_out  output  1/3/5/1/1/32  registered pass-through
out_regwrite_enable  output  1  registered; forced 0 when out_valid=0
mem_out  output  32  extended load data; 0 for non-loads
mem_exception  output  3  bit0 misaligned, bit1 bus error, bit2 timeout

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States: IDLE, REQ.
- in_stall = (state==REQ). Accept = in_valid & ~in_stall.
- Bypass path: on accept with memop_disable=1, or neither read nor write, or any upstream exception nonzero:
  - No bus activity.
  - Outputs registered at that edge; out_valid=1 the next cycle (latency 1).
  - mem_out=0, mem_exception=0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - Latency-1 retire with mem_exception[0]=1 and no bus access.
- Bus path: on accept, go to REQ and latch addr/size/signed/we/data.
  - dmem_req=1 from the next cycle.
  - dmem_addr, dmem_be, dmem_we, dmem_wdata stay stable until ack/err.
  - be: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hF.
  - wdata: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- On an edge in REQ with ack=1 (ack has priority over err if both are high):
  - Go to IDLE; dmem_req=0 next cycle; out_valid=1 next cycle.
  - Load: mem_out = lane selected by addr[1:0] (half: addr[1]), extended per in_mem_signed.
  - Store: mem_out=0.
  - in_stall drops the same cycle as out_valid, so a new instruction may be accepted then.
- Error: err=1 with ack=0 → same retirement with mem_exception[1]=1 and mem_out=0.
- Minimum bus-op latency: 2 cycles from accept to out_valid.
- Spurious ack/err in IDLE is ignored.
- out_valid is high exactly one cycle per accepted instruction. When out_valid=0, pass-through fields hold their last values, but out_regwrite_enable=0.
- Reset mid-REQ: IDLE next cycle, dmem_req=0, no out_valid; a later ack is ignored.

Optional Feature:
PIPELINE_MEMORY_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: IDLE, dmem_req low, retire with mem_exception[2]=1, mem_out=0.
  - An ack in the same cycle as the limit wins.
- Undefined: no counter; REQ waits indefinitely; mem_exception[2] is tied 0.

Test Plan:
- ALU op (memop_disable=1, alu_out=0x1234): out_valid next cycle, out_alu_out=0x1234, no dmem_req.
- lb signed at 0x1003, rdata=0x80FF_FF_FF, ack after 3 wait cycles: in_stall high 4 cycles, then mem_out=0xFFFFFF80, mem_exception=0.
- sh at 0x2002, data=0xABCD1234: dmem_be=4'b1100, dmem_wdata=0x12341234, dmem_we=1; after ack mem_out=0.
- lw at 0x3001: next cycle mem_exception=3'b001, out_regwrite_enable=1 (writeback suppresses), dmem_req never asserted.
- lw with dmem_err=1: mem_exception=3'b010, mem_out=0. With ack+err asserted together: treated as success.
- rst in the 2nd REQ cycle: dmem_req=0 next cycle, no out_valid, a late ack is ignored. Timeout build with TIMEOUT_CYCLES=4 and no ack: mem_exception=3'b100.
